mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (port 0) and load/store (port 1).
//  Drives the select_signal of the existing 32-bit 2:1 address/data mux (sel=0 fetch, sel=1 data).
//  Sequences each access with a valid/ready handshake and a timeout.
//  Sits between the PC/LSU request logic and the memory wrapper; stall logic consumes busy/ack.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in ACCESS without mem_ready before forced completion; legal >=1
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req_0      in   1  fetch request; held high until ack_0
//  req_1      in   1  data request; held high until ack_1
//  we_1       in   1  data write enable, sampled at grant
//  mem_ready  in   1  memory completes current access this cycle
//  sel        out  1  mux select (0=port 0, 1=port 1), registered
//  mem_valid  out  1  access in progress toward memory
//  mem_we     out  1  write strobe; only ever 1 for port-1 grants
//  ack_0      out  1  one-cycle completion pulse, port 0
//  ack_1      out  1  one-cycle completion pulse, port 1
//  busy       out  1  high whenever state != IDLE
//  err        out  1  one-cycle pulse, coincident with ack, on timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel=0, mem_valid=0, mem_we=0, ack_0/1=0, err=0,
//   busy=0, last_grant=1 (fetch wins first tie), wait_cnt=0. Mid-access reset aborts silently.
//  States: IDLE -> ACCESS -> RESP -> IDLE; all outputs registered.
//  IDLE: no req -> stay. One req -> grant it. Both -> grant port != last_grant.
//   On grant: sel<=port, mem_we<=(port==1)&we_1, mem_valid<=1, last_grant<=port, wait_cnt<=0.
//  ACCESS: sel/mem_we held stable. mem_ready=1 -> RESP, mem_valid<=0, mem_we<=0,
//   ack_<sel><=1. Else wait_cnt++; when wait_cnt==TIMEOUT_CYCLES-1 and no mem_ready
//   -> RESP with ack_<sel><=1 and err<=1 (requester never hangs).
//  RESP: ack/err high exactly this cycle; next cycle -> IDLE, ack/err<=0, sel held.
//  Latency: req high in IDLE at edge N -> mem_valid at N+1; mem_ready at edge M -> ack at M+1.
//   Minimum 3 cycles per transfer (zero-wait memory); back-to-back grants alternate on tie.
//  Requests arriving during ACCESS/RESP wait; no request is dropped or reordered.
//  Request deasserted mid-access: access still completes and ack is still pulsed.
//  mem_ready outside ACCESS ignored. ack_0 and ack_1 never high together.
//  wait_cnt width = $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
// STRUCTURE
//  Shared package mem_arb_pkg: state localparams ARB_IDLE=2'd0, ARB_ACCESS=2'd1,
//   ARB_RESP=2'd2; SEL_FETCH=1'b0, SEL_DATA=1'b1 (also used by the mux instance).
//  One sub-module: arb_wait_counter (clear/enable/terminal-count flag, TIMEOUT_CYCLES param).
//  Address/write-data mux stays outside; top level wires sel to its select_signal.
// TESTING
//  Reset: rst_n=0 mid-ACCESS -> all outputs 0 same cycle; first tie after release grants port 0.
//  Single fetch, mem_ready 1 cycle after valid -> sel=0, mem_we=0, ack_0 pulse 1 cycle, err=0.
//  req_0=req_1=1 held, we_1=1, zero-wait memory -> grants 0,1,0,1; mem_we=1 only on port-1.
//  TIMEOUT_CYCLES=4, mem_ready stuck 0 -> ack_1 and err pulse together 4 cycles after mem_valid.
//  req_1 dropped during ACCESS -> access finishes, ack_1 still pulses, IDLE afterwards.
//  Random req/ready stream, 10k cycles -> no double ack, sel stable across ACCESS, no starvation.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory-port arbiter and the address/data mux it steers.
package mem_arb_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state counter for one memory access: clears on grant, counts stalled cycles, saturates.
module arb_wait_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TcVal  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] MaxVal = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (port 0) and load/store (port 1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0_i,
  input  logic req_1_i,
  input  logic we_1_i,
  input  logic mem_ready_i,
  output logic sel_o,
  output logic mem_valid_o,
  output logic mem_we_o,
  output logic ack_0_o,
  output logic ack_1_o,
  output logic busy_o,
  output logic err_o
);

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       we_q, we_d;
  logic       ack_0_q, ack_0_d;
  logic       ack_1_q, ack_1_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       last_q, last_d;
  logic       port;
  logic       cnt_clr, cnt_en, cnt_tc;

  arb_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  // On a tie the port that did not win last time gets the grant.
  assign port = (req_0_i && req_1_i) ? ~last_q : (req_1_i ? SEL_DATA : SEL_FETCH);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    we_d    = we_q;
    last_d  = last_q;
    ack_0_d = 1'b0;
    ack_1_d = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req_0_i || req_1_i) begin
          state_d = ARB_ACCESS;
          sel_d   = port;
          we_d    = (port == SEL_DATA) && we_1_i;
          valid_d = 1'b1;
          last_d  = port;
          cnt_clr = 1'b1;
        end
      end
      ARB_ACCESS: begin
        if (mem_ready_i || cnt_tc) begin
          state_d = ARB_RESP;
          valid_d = 1'b0;
          we_d    = 1'b0;
          ack_0_d = (sel_q == SEL_FETCH);
          ack_1_d = (sel_q == SEL_DATA);
          err_d   = !mem_ready_i;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= SEL_FETCH;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      ack_0_q <= 1'b0;
      ack_1_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= SEL_DATA;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      ack_0_q <= ack_0_d;
      ack_1_q <= ack_1_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign sel_o       = sel_q;
  assign mem_valid_o = valid_q;
  assign mem_we_o    = we_q;
  assign ack_0_o     = ack_0_q;
  assign ack_1_o     = ack_1_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
